// File: rtl/flash_exerciser.sv
// flash_exerciser: write/read-back traffic generator for the SPI flash controller
// CPU-side handshake. Writes a deterministic pattern over a window of NUM_WORDS words,
// reads it back and reports pass/fail, a saturating error count and the first bad address.
// Optional feature macro: FLASH_EXER_LFSR_EN selects a 32-bit Galois LFSR pattern instead
// of the default address-XOR-iteration pattern.
module flash_exerciser #(
  parameter int unsigned       ADDR_W     = 24,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       WORD_BYTES = 4,
  parameter int unsigned       NUM_WORDS  = 1024,
  parameter logic [ADDR_W-1:0] START_ADDR = 24'h000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  output logic              flash_en,
  output logic              flash_write,
  output logic [ADDR_W-1:0] flash_addr,
  output logic [DATA_W-1:0] flash_data_in,
  input  logic              flash_ready,
  input  logic [DATA_W-1:0] flash_data_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [7:0]        iter
);

  localparam int unsigned    IdxW    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StDone} state_e;

  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [7:0]        iter_q, iter_d;
  logic [15:0]       err_q, err_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] pattern;
  logic              pat_seed, pat_step;
  logic              active;

  assign addr   = START_ADDR + ADDR_W'(idx_q) * ADDR_W'(WORD_BYTES);
  assign active = (state_q == StWrite) || (state_q == StRead);

`ifdef FLASH_EXER_LFSR_EN
  localparam logic [31:0] LfsrSeed = 32'hACE1_0001;
  localparam logic [31:0] LfsrTaps = 32'h8020_0003;

  logic [31:0] lfsr_q, lfsr_d;

  if (DATA_W != 32) begin : gen_data_w_check
    $error("flash_exerciser: DATA_W must be 32 when FLASH_EXER_LFSR_EN is defined");
  end

  // Reseed at the start of every pass so write and read passes see the same sequence.
  always_comb begin
    lfsr_d = lfsr_q;
    if (pat_seed) begin
      lfsr_d = LfsrSeed ^ {24'd0, iter_d};
    end else if (pat_step) begin
      lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LfsrTaps) : (lfsr_q >> 1);
    end
  end

  // LFSR state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign pattern = DATA_W'(lfsr_q);
`else
  logic unused_pat;

  assign pattern    = DATA_W'(addr) ^ {(DATA_W / 8){iter_q}};
  assign unused_pat = pat_seed ^ pat_step;
`endif

  // Next-state logic: abort wins over start and flash_ready and freezes all counters.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    idx_d    = idx_q;
    iter_d   = iter_q;
    err_d    = err_q;
    first_d  = first_q;
    pat_seed = 1'b0;
    pat_step = 1'b0;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            mode_d   = mode;
            idx_d    = '0;
            iter_d   = '0;
            err_d    = '0;
            first_d  = '1;
            pat_seed = 1'b1;
            state_d  = (mode == 2'b10) ? StRead : StWrite;
          end
        end
        StWrite: begin
          if (flash_ready) begin
            if (idx_q == LastIdx) begin
              idx_d    = '0;
              pat_seed = 1'b1;
              state_d  = (mode_q == 2'b01) ? StDone : StRead;
            end else begin
              idx_d    = idx_q + IdxW'(1);
              pat_step = 1'b1;
            end
          end
        end
        StRead: begin
          if (flash_ready) begin
            if (flash_data_out != pattern) begin
              if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
              if (first_q == '1) first_d = addr;
            end
            if (idx_q == LastIdx) begin
              idx_d = '0;
              if (mode_q == 2'b11) begin
                iter_d   = iter_q + 8'd1;
                pat_seed = 1'b1;
                state_d  = StWrite;
              end else begin
                state_d = StDone;
              end
            end else begin
              idx_d    = idx_q + IdxW'(1);
              pat_step = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      mode_q  <= 2'b00;
      idx_q   <= '0;
      iter_q  <= '0;
      err_q   <= '0;
      first_q <= '1;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      iter_q  <= iter_d;
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

  // Outputs depend on registered state only; address/data are zero outside a transfer.
  always_comb begin
    busy           = active;
    flash_en       = active;
    flash_write    = (state_q == StWrite);
    flash_addr     = active ? addr : '0;
    flash_data_in  = active ? pattern : '0;
    done           = (state_q == StDone);
    pass           = (state_q == StDone) && (err_q == 16'd0);
    err_count      = err_q;
    first_err_addr = first_q;
    iter           = iter_q;
  end

endmodule
